// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg -- shared encodings for the ff_bank flip-flop bank.
//   mode_e     : per-edge function select (SR, JK, D, T)
//   INV_*      : SR-mode resolution policy for s=r=1
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam int INV_HOLD  = 0;
  localparam int INV_RESET = 1;
  localparam int INV_SET   = 2;

endpackage

// File: rtl/ff_cell.sv
// ff_cell -- one bit of the configurable flip-flop bank.
//   clk, rst   : clock, synchronous active-high reset (q <= RST_VAL)
//   en         : update enable, 0 holds q
//   mode       : SR / JK / D / T select
//   a, b       : S/J/D/T and R/K inputs for this bit
//   q          : registered bit
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic RST_VAL    = 1'b0,
  parameter int   INV_POLICY = INV_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q
);

  logic q_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    q_next = q;
    unique case (mode_e'(mode))
      MODE_SR: begin
        unique case ({a, b})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: begin
            // Out-of-range policy values fall back to hold so q is never X.
            case (INV_POLICY)
              INV_RESET: q_next = 1'b0;
              INV_SET:   q_next = 1'b1;
              default:   q_next = q;
            endcase
          end
        endcase
      end
      MODE_JK: begin
        unique case ({a, b})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: q_next = ~q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= q_next;
  end

endmodule

// File: rtl/ff_bank.sv
// ff_bank -- WIDTH independent flip-flops sharing one mode select, plus
// SR-mode invalid-input (s=r=1) detection.
//   clk, rst   : clock, synchronous active-high reset
//   en         : update enable; 0 holds q and suppresses invalid detection
//   mode       : 00 SR, 01 JK, 10 D, 11 T
//   a, b       : per-bit S/J/D/T and R/K inputs
//   err_clr    : clears err_sticky (and err_cnt)
//   q, qn      : registered state and its complement
//   invalid    : one-cycle pulse after an enabled SR edge with any a&b bit set
//   err_sticky : latched invalid indication
//   err_cnt    : saturating invalid-event count, present only when the
//                FF_BANK_ERR_CNT_EN macro is defined
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter int               INV_POLICY = INV_HOLD,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             invalid,
  output logic             err_sticky
`ifdef FF_BANK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
    $error("ff_bank: WIDTH must be 1..64 and CNT_W at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_VAL   (RST_VAL[i]),
      .INV_POLICY(INV_POLICY)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .mode(mode),
      .a   (a[i]),
      .b   (b[i]),
      .q   (q[i])
    );
  end

  assign qn = ~q;

  // One event per edge, however many bits have s=r=1.
  logic inv_event;
  assign inv_event = en && (mode_e'(mode) == MODE_SR) && (|(a & b));

  always_ff @(posedge clk) begin
    if (rst) begin
      invalid    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      invalid <= inv_event;
      // A new event wins over a simultaneous clear.
      if (inv_event)    err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

`ifdef FF_BANK_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst)                              err_cnt <= '0;
    else if (err_clr)                     err_cnt <= inv_event ? CNT_W'(1) : '0;
    else if (inv_event && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
  end
`endif

endmodule
